shot_dispatcher: RTL
====================

SHOT_DISPATCHER -- requirements
Module: shot_dispatcher

Interface
REQ-001 SHALL have parameter: COOLDOWN_FRAMES, 8, frames (startOfFrame pulses) between accepted shots; legal range 1..255.
REQ-002 SHALL have port: clk  input  1  system clock (50 MHz); all logic on rising edge.
REQ-003 SHALL have port: resetN  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: startOfFrame  input  1  one-clock pulse per video frame.
REQ-005 SHALL have port: shoot  input  1  fire button, active-high, asynchronous to clk, undebounced.
REQ-006 SHALL have port: player_active  input  1  player may fire when 1.
REQ-007 SHALL have port: shots_active  input  8  per-slot busy flags from the shot objects.
REQ-008 SHALL have port: deploy_shot  output  8  one-hot, one-clock launch pulse to a shot slot.
REQ-009 SHALL have port: shot_dropped  output  1  one-clock pulse: press accepted but no free slot.
REQ-010 SHALL have port: cooldown  output  1  high while in COOLDOWN state.
REQ-011 SHALL have port: shots_live  output  4  registered popcount of shots_active, 0..8.

Function
REQ-012 SHALL pass shoot through a 2-flop synchroniser, then a rising-edge detector (sync high, previous sync low) producing press, one clock wide.
REQ-013 SHALL implement states IDLE, SEARCH, FIRE, WAIT_ACK, COOLDOWN; one state register, no other FSM.
REQ-014 IDLE: on press with player_active=1 -> SEARCH; press with player_active=0 -> ignored, stay IDLE.
REQ-015 SEARCH (one clock): scan slots rr_ptr, rr_ptr+1, ... rr_ptr+7 (mod 8); first slot with shots_active=0 latched as sel; found -> FIRE; none -> assert shot_dropped that clock, -> IDLE.
REQ-016 FIRE (one clock): deploy_shot[sel]=1, all other bits 0; rr_ptr <= (sel+1) mod 8; -> WAIT_ACK.
REQ-017 Latency: deploy_shot SHALL assert exactly 5 clocks after the first clk edge at which shoot is sampled high (2 sync + 1 edge + SEARCH + FIRE), given IDLE and a free slot.
REQ-018 WAIT_ACK: -> COOLDOWN when shots_active[sel]=1 or after 4 clocks in WAIT_ACK, whichever is first; timeout is not an error.
REQ-019 COOLDOWN: load frame counter with COOLDOWN_FRAMES on entry; decrement on each startOfFrame; -> IDLE the clock after the decrement reaching 0.
REQ-020 Presses arriving in SEARCH, FIRE, WAIT_ACK or COOLDOWN SHALL be discarded, not queued.
REQ-021 Held button SHALL fire once only; a new press requires shoot low for at least one synchronised sample.
REQ-022 player_active falling in any non-IDLE state SHALL force -> IDLE next clock, cancelling a pending FIRE (no deploy pulse) and clearing the cooldown counter.
REQ-023 startOfFrame coincident with COOLDOWN entry SHALL NOT decrement the counter.
REQ-024 shots_live SHALL be popcount(shots_active) registered one clock, independent of FSM state.
REQ-025 deploy_shot SHALL never have more than one bit high; shot_dropped and any deploy_shot bit SHALL never be high in the same clock.

Reset
REQ-026 While resetN=0 at a clock edge: state=IDLE, rr_ptr=0, sel=0, frame counter=0, synchroniser and edge flops=0, deploy_shot=8'h00, shot_dropped=0, cooldown=0, shots_live=0.
REQ-027 Reset asserted mid-operation (any state) SHALL take effect at the next edge; no deploy pulse SHALL be emitted during or in the clock after reset release.
REQ-028 shoot held high across reset release SHALL NOT produce a press (edge flops released at 0 then sample high counts only after shoot seen low).

Verification
REQ-029 Reset, shots_active=0, player_active=1, shoot high at edge T -> deploy_shot=8'h01 at T+5 for one clock, cooldown=1 from T+6.
REQ-030 shots_active=8'b0000_0111, rr_ptr=0, press -> deploy_shot=8'h08; next press after cooldown with shots_active=8'b0000_1111 -> 8'h10.
REQ-031 shots_active=8'hFF, press -> shot_dropped pulse 3 clocks after press, deploy_shot stays 0, state back to IDLE, cooldown=0.
REQ-032 COOLDOWN_FRAMES=3, fire, press again after 2 startOfFrame pulses -> no deploy; press after 3rd pulse +1 clock -> deploy issued.
REQ-033 Press, then player_active=0 during SEARCH -> no deploy pulse, state IDLE, rr_ptr unchanged.
REQ-034 shots_active never acknowledges -> WAIT_ACK exits after 4 clocks, cooldown=1; shots_live tracks popcount with 1-clock lag throughout.

Source files
------------

// File: rtl/shot_dispatcher.sv
// Fire-button dispatcher: turns a raw, asynchronous fire button into a single
// one-hot launch pulse toward a free shot slot, then holds off further shots
// for a number of video frames.
//
// Ports
//   clk            system clock, rising edge
//   resetN         synchronous active-low reset
//   startOfFrame   one-clock pulse per video frame
//   shoot          raw fire button (asynchronous, undebounced)
//   player_active  firing allowed when high; low aborts any activity
//   shots_active   per-slot busy flags from the shot objects
//   deploy_shot    one-hot, one-clock launch pulse (registered)
//   shot_dropped   one-clock pulse: press accepted but every slot busy
//   cooldown       high while the frame hold-off is running
//   shots_live     popcount of shots_active, one clock late
module shot_dispatcher #(
    parameter int unsigned COOLDOWN_FRAMES = 8
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       shoot,
    input  logic       player_active,
    input  logic [7:0] shots_active,
    output logic [7:0] deploy_shot,
    output logic       shot_dropped,
    output logic       cooldown,
    output logic [3:0] shots_live
);

    localparam int unsigned NSLOT       = 8;
    localparam int unsigned SLOT_W      = 3;
    localparam int unsigned FCNT_W      = 8;
    localparam int unsigned LIVE_W      = 4;
    localparam int unsigned WAIT_W      = 2;
    localparam int unsigned WAIT_CYCLES = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEARCH,
        ST_FIRE,
        ST_WAIT_ACK,
        ST_COOLDOWN
    } state_e;

    state_e              state_q, state_d;
    logic [SLOT_W-1:0]   rr_q, rr_d;
    logic [SLOT_W-1:0]   sel_q, sel_d;
    logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
    logic [WAIT_W-1:0]   wcnt_q, wcnt_d;
    logic [NSLOT-1:0]    deploy_q, deploy_d;
    logic                drop_q, drop_d;
    logic                cool_q, cool_d;
    logic [LIVE_W-1:0]   live_q, live_d;

    // Button front end
    logic                sync1_q, sync2_q, prev_q;
    logic [1:0]          vld_q;
    logic                armed_q, armed_d;
    logic                press_q, press_d;

    logic                found_c;
    logic [SLOT_W-1:0]   pick_c;

    // A press needs a genuine low sample first, so a button held through
    // reset release cannot fire. vld_q[1] marks sync2_q as a real sample.
    always_comb begin
        armed_d = armed_q | (vld_q[1] & ~sync2_q);
        press_d = armed_q & sync2_q & ~prev_q;
    end

    // Round-robin search for the first idle slot starting at rr_q
    always_comb begin
        found_c = 1'b0;
        pick_c  = '0;
        for (int unsigned i = 0; i < NSLOT; i++) begin
            if (!found_c && !shots_active[SLOT_W'(rr_q + SLOT_W'(i))]) begin
                found_c = 1'b1;
                pick_c  = SLOT_W'(rr_q + SLOT_W'(i));
            end
        end
    end

    // Popcount of busy slots
    always_comb begin
        live_d = '0;
        for (int unsigned i = 0; i < NSLOT; i++) begin
            live_d = live_d + LIVE_W'(shots_active[i]);
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        sel_d    = sel_q;
        fcnt_d   = fcnt_q;
        wcnt_d   = wcnt_q;
        deploy_d = '0;
        drop_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (press_q && player_active) begin
                    state_d = ST_SEARCH;
                end
            end
            ST_SEARCH: begin
                if (found_c) begin
                    sel_d   = pick_c;
                    state_d = ST_FIRE;
                end else begin
                    drop_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_FIRE: begin
                deploy_d = NSLOT'(1) << sel_q;
                rr_d     = SLOT_W'(sel_q + SLOT_W'(1));
                wcnt_d   = '0;
                state_d  = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                // Leave on slot acknowledge or after WAIT_CYCLES clocks here
                if (shots_active[sel_q] || (wcnt_q == WAIT_W'(WAIT_CYCLES - 1))) begin
                    fcnt_d  = FCNT_W'(COOLDOWN_FRAMES);
                    state_d = ST_COOLDOWN;
                end else begin
                    wcnt_d = wcnt_q + WAIT_W'(1);
                end
            end
            ST_COOLDOWN: begin
                // Counter loaded on entry, so a frame pulse on the entry clock is not counted
                if (fcnt_q == '0) begin
                    state_d = ST_IDLE;
                end else if (startOfFrame) begin
                    fcnt_d = fcnt_q - FCNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Losing the player aborts everything, including a pending launch
        if ((state_q != ST_IDLE) && !player_active) begin
            state_d  = ST_IDLE;
            rr_d     = rr_q;
            sel_d    = sel_q;
            fcnt_d   = '0;
            deploy_d = '0;
            drop_d   = 1'b0;
        end

        cool_d = (state_d == ST_COOLDOWN);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q  <= ST_IDLE;
            rr_q     <= '0;
            sel_q    <= '0;
            fcnt_q   <= '0;
            wcnt_q   <= '0;
            deploy_q <= '0;
            drop_q   <= 1'b0;
            cool_q   <= 1'b0;
            live_q   <= '0;
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            prev_q   <= 1'b0;
            vld_q    <= '0;
            armed_q  <= 1'b0;
            press_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            sel_q    <= sel_d;
            fcnt_q   <= fcnt_d;
            wcnt_q   <= wcnt_d;
            deploy_q <= deploy_d;
            drop_q   <= drop_d;
            cool_q   <= cool_d;
            live_q   <= live_d;
            sync1_q  <= shoot;
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            vld_q    <= {vld_q[0], 1'b1};
            armed_q  <= armed_d;
            press_q  <= press_d;
        end
    end

    assign deploy_shot  = deploy_q;
    assign shot_dropped = drop_q;
    assign cooldown     = cool_q;
    assign shots_live   = live_q;

endmodule
